// File: rtl/reg_bus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_pkg
//   Shared definitions for the peripheral register-bus arbiter:
//   FSM state encoding, master index constants and default bus widths.
// -----------------------------------------------------------------------------
package reg_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STROBE = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DBG  = 1'b1;

  localparam int BW_DEF = 32;
  localparam int AW_DEF = 4;

endpackage

// File: rtl/reg_bus_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-request round-robin arbiter, purely combinational.
//   Ports:
//     req[1:0]    request lines (bit 0 = CORE, bit 1 = DBG)
//     last_grant  index of the master served most recently
//     en          arbitration enable; grant is forced to CORE when low
//     grant       index of the winning master
// -----------------------------------------------------------------------------
module rr_arb2
  import reg_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic       grant
);

  always_comb begin
    grant = M_CORE;
    if (en) begin
      // On a tie the master that was not served last wins.
      if (req == 2'b11) grant = ~last_grant;
      else if (req[1])  grant = M_DBG;
      else              grant = M_CORE;
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// -----------------------------------------------------------------------------
// reg_bus_arb
//   Two-master arbiter/sequencer for the peripheral register bank.
//   Master 0 is the CORE load/store port, master 1 the debug/DMA port.
//   One access at a time: IDLE (arbitrate, latch) -> STROBE (one-hot strobes,
//   capture read data) -> RESP (registered ack + rdata).
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     mN_req/we/addr/wdata       master N request (held until mN_ack)
//     mN_ack, mN_rdata           1-cycle completion pulse, read data (0 else)
//     reg_we, reg_re             one-hot write/read strobes to the bank
//     reg_wdata                  write data to the bank
//     reg_rdata                  OR-combined read data from the bank
//
//   Optional feature macro REG_BUS_ERR_EN: adds m0_err/m1_err outputs and the
//   RO_MASK parameter. err pulses with ack for out-of-range addresses and for
//   writes to read-only registers; such writes get no reg_we strobe.
// -----------------------------------------------------------------------------
module reg_bus_arb
  import reg_bus_pkg::*;
#(
  parameter int BW   = BW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NREG = 16
`ifdef REG_BUS_ERR_EN
  , parameter logic [NREG-1:0] RO_MASK = '0
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [BW-1:0]   m0_wdata,
  output logic            m0_ack,
  output logic [BW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [BW-1:0]   m1_wdata,
  output logic            m1_ack,
  output logic [BW-1:0]   m1_rdata,
  output logic [NREG-1:0] reg_we,
  output logic [NREG-1:0] reg_re,
  output logic [BW-1:0]   reg_wdata,
  input  logic [BW-1:0]   reg_rdata
`ifdef REG_BUS_ERR_EN
  , output logic          m0_err
  , output logic          m1_err
`endif
);

  state_t          state;
  logic            grant;
  logic            last_grant;
  logic            arb_grant;
  logic            any_req;

  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [BW-1:0]   lat_wdata;

  logic [NREG-1:0] dec;
  logic            in_range;
  logic            ro_hit;
  logic [BW-1:0]   rsp_data;

  assign any_req = m0_req | m1_req;

  rr_arb2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .en         (state == ST_IDLE),
    .grant      (arb_grant)
  );

  // Address decode. An address with no matching register leaves dec all-zero,
  // which doubles as the out-of-range indication.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      dec[i] = (int'(lat_addr) == i);
    end
  end

  assign in_range = |dec;

`ifdef REG_BUS_ERR_EN
  assign ro_hit = lat_we & |(dec & RO_MASK);
`else
  assign ro_hit = 1'b0;
`endif

  always_comb begin
    reg_we    = '0;
    reg_re    = '0;
    reg_wdata = '0;
    if (state == ST_STROBE) begin
      reg_wdata = lat_wdata;
      reg_we    = (lat_we && !ro_hit) ? dec : '0;
      reg_re    = lat_we ? '0 : dec;
    end
  end

  assign rsp_data = (!lat_we && in_range) ? reg_rdata : '0;

  // ---- Stage boundary: IDLE -> STROBE, latch the winning master's fields ----
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && any_req) begin
      if (arb_grant == M_DBG) begin
        lat_we    <= m1_we;
        lat_addr  <= m1_addr;
        lat_wdata <= m1_wdata;
      end else begin
        lat_we    <= m0_we;
        lat_addr  <= m0_addr;
        lat_wdata <= m0_wdata;
      end
    end
  end

  // ---- Stage boundary: control FSM, STROBE -> RESP registered response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= M_CORE;
      last_grant <= M_DBG;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
`ifdef REG_BUS_ERR_EN
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
`endif
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
`ifdef REG_BUS_ERR_EN
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= arb_grant;
            state <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          state <= ST_RESP;
          if (grant == M_DBG) begin
            m1_ack   <= 1'b1;
            m1_rdata <= rsp_data;
`ifdef REG_BUS_ERR_EN
            m1_err   <= ~in_range | ro_hit;
`endif
          end else begin
            m0_ack   <= 1'b1;
            m0_rdata <= rsp_data;
`ifdef REG_BUS_ERR_EN
            m0_err   <= ~in_range | ro_hit;
`endif
          end
        end
        ST_RESP: begin
          last_grant <= grant;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A granted master must hold its request until its ack has been seen.
  a_m0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state != ST_IDLE && grant == M_CORE) |-> m0_req);
  a_m1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state != ST_IDLE && grant == M_DBG) |-> m1_req);

endmodule

// File: tb/tb_reg_bus_arb.sv
`timescale 1ns/1ps
module tb_reg_bus_arb;

  localparam int BW   = 32;
  localparam int AW   = 4;
  localparam int NREG = 10;
`ifdef REG_BUS_ERR_EN
  localparam logic [NREG-1:0] RO_TB = 10'h020;
`else
  localparam logic [NREG-1:0] RO_TB = 10'h000;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [BW-1:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic            m0_ack, m1_ack;
  logic [NREG-1:0] reg_we, reg_re;
  logic [BW-1:0]   reg_wdata, reg_rdata;
`ifdef REG_BUS_ERR_EN
  logic            m0_err, m1_err;
`endif

  always #5 clk = ~clk;

  reg_bus_arb #(
    .BW(BW), .AW(AW), .NREG(NREG)
`ifdef REG_BUS_ERR_EN
    , .RO_MASK(RO_TB)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
`ifdef REG_BUS_ERR_EN
    , .m0_err(m0_err), .m1_err(m1_err)
`endif
  );

  // Register bank model driven by the DUT strobes.
  logic          bank_clr;
  logic [BW-1:0] bank [NREG];

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bank_clr)       bank[i] <= '0;
      else if (reg_we[i]) bank[i] <= reg_wdata;
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NREG; i++) if (reg_re[i]) reg_rdata = reg_rdata | bank[i];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected responses, in service order.
  typedef struct {
    int            m;
    logic [BW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb [$];

  function automatic logic exp_err(input logic we, input logic [AW-1:0] a);
    if (int'(a) >= NREG) return 1'b1;
    return we & RO_TB[a];
  endfunction

  task automatic push_exp(input int m, input logic we, input logic [AW-1:0] a,
                          input logic [BW-1:0] rd);
    exp_t e;
    e.m = m; e.rdata = rd; e.err = exp_err(we, a);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!m0_ack) chk("m0_rdata_idle", m0_rdata, 0);
      if (!m1_ack) chk("m1_rdata_idle", m1_rdata, 0);
      if (m0_ack || m1_ack) begin
        chk("single_ack", {m1_ack, m0_ack} == 2'b11, 0);
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_master", m1_ack ? 1 : 0, e.m);
          chk("sb_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
`ifdef REG_BUS_ERR_EN
          chk("sb_err", m1_ack ? m1_err : m0_err, e.err);
`endif
        end
      end
    end
  end

  task automatic drive_req(input int m, input logic we, input logic [AW-1:0] a,
                           input logic [BW-1:0] d);
    if (m == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  typedef struct {
    int              m;
    logic            we;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   wdata;
    logic [NREG-1:0] exp_strobe;
    logic [BW-1:0]   exp_rdata;
  } vec_t;
  vec_t vecs [$];

  // Called just after a posedge with the DUT idle; returns just after the
  // posedge that ends the response cycle.
  task automatic run_vec(input vec_t v);
    push_exp(v.m, v.we, v.addr, v.exp_rdata);
    drive_req(v.m, v.we, v.addr, v.wdata);
    @(negedge clk);
    chk("c0_no_strobe", {reg_we, reg_re}, 0);
    @(negedge clk);
    chk("c1_reg_we", reg_we, v.we ? v.exp_strobe : '0);
    chk("c1_reg_re", reg_re, v.we ? '0 : v.exp_strobe);
    chk("c1_reg_wdata", reg_wdata, v.wdata);
    @(negedge clk);
    chk("c2_ack", (v.m == 0) ? m0_ack : m1_ack, 1);
    @(posedge clk); #1;
    drop_req(v.m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bank_clr = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_acks", {m1_ack, m0_ack}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    rst_n = 1'b1; bank_clr = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests after reset: CORE first, DBG second.
    push_exp(0, 1'b1, 4'd1, '0);
    push_exp(1, 1'b1, 4'd2, '0);
    drive_req(0, 1'b1, 4'd1, 32'h1111_1111);
    drive_req(1, 1'b1, 4'd2, 32'h2222_2222);
    @(negedge clk);
    @(negedge clk); chk("sim_c1_we", reg_we, 10'h002);
    @(negedge clk); chk("sim_c2_m0_ack", m0_ack, 1);
    @(posedge clk); #1; drop_req(0);
    @(negedge clk); chk("sim_c3_idle", {reg_we, reg_re}, 0);
    @(negedge clk); chk("sim_c4_we", reg_we, 10'h004);
    @(negedge clk); chk("sim_c5_m1_ack", m1_ack, 1);
    @(posedge clk); #1; drop_req(1);

    // Continuous requests from both: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, 1'b0, 4'd1, 32'h1111_1111);
      else            push_exp(1, 1'b0, 4'd2, 32'h2222_2222);
    end
    drive_req(0, 1'b0, 4'd1, '0);
    drive_req(1, 1'b0, 4'd2, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      @(negedge clk); chk("alt_re", reg_re, (k % 2 == 0) ? 10'h002 : 10'h004);
      @(negedge clk); chk("alt_ack", {m1_ack, m0_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1; drop_req(0); drop_req(1);

    // Table-driven single accesses
    vecs.push_back('{0, 1'b1, 4'd3,  32'hDEAD_BEEF, 10'h008, 32'h0});
    vecs.push_back('{1, 1'b0, 4'd3,  32'h0,         10'h008, 32'hDEAD_BEEF});
    vecs.push_back('{1, 1'b1, 4'd9,  32'h1234_5678, 10'h200, 32'h0});
    vecs.push_back('{0, 1'b0, 4'd9,  32'h0,         10'h200, 32'h1234_5678});
    vecs.push_back('{0, 1'b0, 4'd12, 32'h0,         10'h000, 32'h0});
    vecs.push_back('{1, 1'b1, 4'd15, 32'hFFFF_FFFF, 10'h000, 32'h0});
    vecs.push_back('{0, 1'b0, 4'd0,  32'h0,         10'h001, 32'h0});
    vecs.push_back('{1, 1'b1, 4'd0,  32'hA5A5_A5A5, 10'h001, 32'h0});
    vecs.push_back('{1, 1'b0, 4'd0,  32'h0,         10'h001, 32'hA5A5_A5A5});
    vecs.push_back('{0, 1'b1, 4'd5,  32'h5555_5555, RO_TB[5] ? 10'h000 : 10'h020, 32'h0});
    vecs.push_back('{1, 1'b0, 4'd5,  32'h0,         10'h020, RO_TB[5] ? 32'h0 : 32'h5555_5555});
    vecs.push_back('{0, 1'b0, 4'd3,  32'h0,         10'h008, 32'hDEAD_BEEF});
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during STROBE: access aborted, re-served after release.
    push_exp(1, 1'b1, 4'd4, '0);
    drive_req(1, 1'b1, 4'd4, 32'h4444_4444);
    @(negedge clk);
    @(negedge clk); chk("rst_mid_strobe_on", reg_we, 10'h010);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", reg_we, 0);
    chk("rst_mid_re", reg_re, 0);
    chk("rst_mid_acks", {m1_ack, m0_ack}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rel_idle", {reg_we, reg_re}, 0);
    @(negedge clk); chk("rst_re_we", reg_we, 10'h010);
    @(negedge clk); chk("rst_re_ack", m1_ack, 1);
    @(posedge clk); #1; drop_req(1);

    run_vec('{0, 1'b0, 4'd4, 32'h0, 10'h010, 32'h4444_4444});
    run_vec('{1, 1'b0, 4'd3, 32'h0, 10'h008, 32'hDEAD_BEEF});

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
